udp_checksum_word_sequencer: RTL and testbench

//  Upstream feeder for checksum_calculator on the UDP TX/RX path.

---
 rtl/udp_checksum_word_sequencer_pkg.sv | 33 +++
 rtl/udp_checksum_word_sequencer_if.sv | 38 +++
 rtl/udp_checksum_word_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_udp_checksum_word_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_checksum_word_sequencer_pkg.sv
// Shared definitions for the UDP checksum word sequencer: header geometry,
// FSM encoding, captured header record and the payload length helper.
package udp_checksum_word_sequencer_pkg;

  localparam int         UDP_HDR_BYTES = 8;
  localparam int         PSEUDO_WORDS  = 6;
  localparam int         HDR_WORDS     = 10;
  localparam logic [7:0] UDP_PROTOCOL  = 8'h11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_HDR     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_WAIT    = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] udp_length;
  } udp_hdr_t;

  // Payload words implied by the UDP length field; an odd trailing byte
  // still occupies a full word.
  function automatic logic [15:0] expected_words(input logic [15:0] udp_length);
    logic [15:0] body;
    body = udp_length - 16'(UDP_HDR_BYTES) + 16'd1;
    return body >> 1;
  endfunction

endpackage

// File: rtl/udp_checksum_word_sequencer_if.sv
// Payload stream in, checksum-calculator word stream out.
// master: the sequencer; slave: payload source / calculator side.
interface udp_checksum_word_sequencer_if #(
  parameter int LENGTH = 16
);

  logic [LENGTH-1:0] payload_data;
  logic              payload_valid;
  logic              payload_last;
  logic              payload_odd;
  logic              payload_ready;
  logic [LENGTH-1:0] word_out;
  logic              word_valid;
  logic              chk_clear;

  modport master (
    input  payload_data,
    input  payload_valid,
    input  payload_last,
    input  payload_odd,
    output payload_ready,
    output word_out,
    output word_valid,
    output chk_clear
  );

  modport slave (
    output payload_data,
    output payload_valid,
    output payload_last,
    output payload_odd,
    input  payload_ready,
    input  word_out,
    input  word_valid,
    input  chk_clear
  );

endinterface

// File: rtl/udp_checksum_word_sequencer.sv
// Serialises pseudo-header, UDP header and payload into 16-bit words for the
// checksum calculator, and checks the payload length against udp_length.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for start; captured fields and length_error held
// ST_CLEAR   | one-cycle chk_clear to the calculator
// ST_HDR     | ten header words, one per cycle, no stalls
// ST_PAYLOAD | payload_ready=1, words forwarded as they arrive
// ST_WAIT    | DONE_DELAY cycles for the calculator output to settle
// ST_DONE    | one-cycle done pulse, length_error valid
module udp_checksum_word_sequencer
  import udp_checksum_word_sequencer_pkg::*;
#(
  parameter int         LENGTH     = 16,
  parameter logic [7:0] PROTOCOL   = UDP_PROTOCOL,
  parameter int         DONE_DELAY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [31:0]                   src_ip,
  input  logic [31:0]                   dst_ip,
  input  logic [15:0]                   src_port,
  input  logic [15:0]                   dst_port,
  input  logic [15:0]                   udp_length,
  udp_checksum_word_sequencer_if.master dp,
  output logic                          busy,
  output logic                          done,
  output logic                          length_error
);

  localparam int                WAIT_W       = 8;
  localparam logic [WAIT_W-1:0] WAIT_LOAD    = WAIT_W'(DONE_DELAY - 1);
  localparam logic [3:0]        LAST_HDR_IDX = 4'(HDR_WORDS - 1);
  localparam logic [15:0]       MIN_LENGTH   = 16'(UDP_HDR_BYTES);

  if (LENGTH != 16) begin : g_length_check
    $error("udp_checksum_word_sequencer: only LENGTH=16 is supported");
  end
  if (DONE_DELAY < 1 || DONE_DELAY > (1 << WAIT_W)) begin : g_delay_check
    $error("udp_checksum_word_sequencer: DONE_DELAY out of range");
  end
  if (PSEUDO_WORDS + UDP_HDR_BYTES / 2 != HDR_WORDS) begin : g_hdr_check
    $error("udp_checksum_word_sequencer: inconsistent header geometry");
  end

  logic [2:0]        state;
  logic [3:0]        hdr_idx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [15:0]       word_cnt;
  logic [15:0]       word_cnt_inc;
  udp_hdr_t          hdr;
  logic              busy_q;
  logic              len_err_q;
  logic              err_pending;
  logic              accept;
  logic              last_accept;
  logic              last_err;
  logic              short_len;
  logic [15:0]       hdr_word;

  assign accept       = (state == ST_PAYLOAD) && dp.payload_valid;
  assign last_accept  = accept && dp.payload_last;
  assign word_cnt_inc = (word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1;
  assign short_len    = hdr.udp_length < MIN_LENGTH;
  assign last_err     = (word_cnt_inc != expected_words(hdr.udp_length))
                      || (dp.payload_odd != hdr.udp_length[0]);

  always_comb begin
    hdr_word = 16'h0000;
    case (hdr_idx)
      4'd0:    hdr_word = hdr.src_ip[31:16];
      4'd1:    hdr_word = hdr.src_ip[15:0];
      4'd2:    hdr_word = hdr.dst_ip[31:16];
      4'd3:    hdr_word = hdr.dst_ip[15:0];
      4'd4:    hdr_word = {8'h00, PROTOCOL};
      4'd5:    hdr_word = hdr.udp_length;
      4'd6:    hdr_word = hdr.src_port;
      4'd7:    hdr_word = hdr.dst_port;
      4'd8:    hdr_word = hdr.udp_length;
      default: hdr_word = 16'h0000;
    endcase
  end

  // Payload words pass straight through so the calculator sees them in the
  // same cycle they are accepted; a trailing odd byte is zero-padded.
  always_comb begin
    dp.word_out   = 16'h0000;
    dp.word_valid = 1'b0;
    case (state)
      ST_HDR: begin
        dp.word_out   = hdr_word;
        dp.word_valid = 1'b1;
      end
      ST_PAYLOAD: begin
        dp.word_out[15:8] = dp.payload_data[15:8];
        dp.word_out[7:0]  = (dp.payload_last && dp.payload_odd) ? 8'h00
                                                                 : dp.payload_data[7:0];
        dp.word_valid     = dp.payload_valid;
      end
      default: begin
        dp.word_out   = 16'h0000;
        dp.word_valid = 1'b0;
      end
    endcase
  end

  assign dp.chk_clear     = (state == ST_CLEAR);
  assign dp.payload_ready = (state == ST_PAYLOAD);
  assign done             = (state == ST_DONE);
  assign busy             = busy_q;
  assign length_error     = len_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      hdr_idx     <= 4'd0;
      wait_cnt    <= '0;
      word_cnt    <= 16'd0;
      hdr         <= '0;
      busy_q      <= 1'b0;
      len_err_q   <= 1'b0;
      err_pending <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            hdr.src_ip     <= src_ip;
            hdr.dst_ip     <= dst_ip;
            hdr.src_port   <= src_port;
            hdr.dst_port   <= dst_port;
            hdr.udp_length <= udp_length;
            busy_q         <= 1'b1;
            len_err_q      <= 1'b0;
            err_pending    <= 1'b0;
            word_cnt       <= 16'd0;
            hdr_idx        <= 4'd0;
            state          <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          hdr_idx <= 4'd0;
          state   <= ST_HDR;
        end
        ST_HDR: begin
          if (hdr_idx == LAST_HDR_IDX) begin
            hdr_idx <= 4'd0;
            if (hdr.udp_length > MIN_LENGTH) begin
              state <= ST_PAYLOAD;
            end else begin
              err_pending <= short_len;
              wait_cnt    <= WAIT_LOAD;
              state       <= ST_WAIT;
            end
          end else begin
            hdr_idx <= hdr_idx + 4'd1;
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            word_cnt <= word_cnt_inc;
          end
          if (last_accept) begin
            err_pending <= last_err;
            wait_cnt    <= WAIT_LOAD;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            len_err_q <= err_pending;
            state     <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_checksum_word_sequencer.sv
// Directed bench for udp_checksum_word_sequencer with a behavioural
// ones-complement accumulator standing in for the checksum calculator.
module tb_udp_checksum_word_sequencer;

  localparam int DONE_DELAY = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] src_port, dst_port, udp_length;
  logic        busy, done, length_error;

  udp_checksum_word_sequencer_if bus ();

  udp_checksum_word_sequencer #(
    .DONE_DELAY(DONE_DELAY)
  ) dut (
    .clk         (clk),
    .reset       (reset_n),
    .start       (start),
    .src_ip      (src_ip),
    .dst_ip      (dst_ip),
    .src_port    (src_port),
    .dst_port    (dst_port),
    .udp_length  (udp_length),
    .dp          (bus),
    .busy        (busy),
    .done        (done),
    .length_error(length_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Calculator model and event recorder, sampled mid-cycle.
  int          cycle = 0;
  int          wv_cnt, done_cnt, clr_cnt, rdy_cnt, last_wv_cycle, done_cycle;
  logic [15:0] csum, last_word;
  logic        busy_at_done, err_at_done;
  logic [16:0] sum17;

  always @(negedge clk) begin
    cycle++;
    if (bus.chk_clear) begin
      csum = 16'h0000;
      clr_cnt++;
    end
    if (bus.word_valid) begin
      sum17 = {1'b0, csum} + {1'b0, bus.word_out};
      csum  = sum17[15:0] + {15'd0, sum17[16]};
      last_word = bus.word_out;
      wv_cnt++;
      last_wv_cycle = cycle;
    end
    if (bus.payload_ready) rdy_cnt++;
    if (done) begin
      done_cnt++;
      done_cycle   = cycle;
      busy_at_done = busy;
      err_at_done  = length_error;
    end
  end

  typedef struct {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] udp_length;
    int          n_pl;
    logic [15:0] pl0;
    logic [15:0] pl1;
    logic        odd;
    bit          gap;
    int          exp_words;
    logic [15:0] exp_sum;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic [31:0] s, input logic [31:0] d,
                              input logic [15:0] sp, input logic [15:0] dpt,
                              input logic [15:0] len, input int n,
                              input logic [15:0] p0, input logic [15:0] p1,
                              input logic odd, input bit gap, input int ew,
                              input logic [15:0] es, input logic ee);
    vec_t v;
    v.src_ip = s; v.dst_ip = d; v.src_port = sp; v.dst_port = dpt;
    v.udp_length = len; v.n_pl = n; v.pl0 = p0; v.pl1 = p1; v.odd = odd;
    v.gap = gap; v.exp_words = ew; v.exp_sum = es; v.exp_err = ee;
    return v;
  endfunction

  task automatic clear_counts();
    wv_cnt = 0; done_cnt = 0; clr_cnt = 0; rdy_cnt = 0;
    last_wv_cycle = 0; done_cycle = 0; last_word = 16'h0000;
    busy_at_done = 1'b0; err_at_done = 1'b0;
  endtask

  task automatic load_fields(input vec_t v);
    src_ip = v.src_ip; dst_ip = v.dst_ip; src_port = v.src_port;
    dst_port = v.dst_port; udp_length = v.udp_length;
  endtask

  task automatic run_vector(input vec_t v, input int id, input bit poke);
    logic [15:0] w, exp_last;
    bit          accepted;
    int          guard;
    string       tag;
    tag = $sformatf("v%0d", id);
    @(posedge clk); #1;
    clear_counts();
    load_fields(v);
    start = 1'b1;
    // Payload is presented before PAYLOAD is reached; it must not be consumed early.
    bus.payload_valid = 1'b1;
    bus.payload_data  = (v.n_pl > 0) ? v.pl0 : 16'h5555;
    bus.payload_last  = (v.n_pl == 1);
    bus.payload_odd   = (v.n_pl == 1) ? v.odd : 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; src_ip = 32'hdeadbeef; udp_length = 16'h0008;
      @(posedge clk); #1;
      start = 1'b0;
      load_fields(v);
    end
    for (int i = 0; i < v.n_pl; i++) begin
      w = (i == 0) ? v.pl0 : v.pl1;
      bus.payload_valid = 1'b1;
      bus.payload_data  = w;
      bus.payload_last  = (i == v.n_pl - 1);
      bus.payload_odd   = (i == v.n_pl - 1) ? v.odd : 1'b0;
      accepted = 1'b0;
      guard = 0;
      while (!accepted && guard < 60) begin
        @(negedge clk);
        accepted = bus.payload_ready;
        @(posedge clk); #1;
        guard++;
      end
      check({tag, "_accept_timeout"}, {31'd0, accepted}, 32'd1);
      if (v.gap && i < v.n_pl - 1) begin
        bus.payload_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    guard = 0;
    while (done_cnt == 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_done_timeout"}, {31'd0, (done_cnt > 0)}, 32'd1);
    bus.payload_valid = 1'b0; bus.payload_last = 1'b0; bus.payload_odd = 1'b0;
    repeat (5) @(negedge clk);
    exp_last = 16'h0000;
    if (v.n_pl > 0) begin
      exp_last = (v.n_pl == 1) ? v.pl0 : v.pl1;
      if (v.odd) exp_last[7:0] = 8'h00;
    end
    check({tag, "_words"},     wv_cnt, v.exp_words);
    check({tag, "_checksum"},  {16'd0, csum}, {16'd0, v.exp_sum});
    check({tag, "_last_word"}, {16'd0, last_word}, {16'd0, exp_last});
    check({tag, "_len_err"},   {31'd0, err_at_done}, {31'd0, v.exp_err});
    check({tag, "_err_hold"},  {31'd0, length_error}, {31'd0, v.exp_err});
    check({tag, "_done_cnt"},  done_cnt, 1);
    check({tag, "_clear_cnt"}, clr_cnt, 1);
    check({tag, "_done_lat"},  done_cycle - last_wv_cycle, 1 + DONE_DELAY);
    check({tag, "_busy_done"}, {31'd0, busy_at_done}, 32'd1);
    check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    if (v.n_pl == 0) check({tag, "_no_ready"}, rdy_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    vecs[0] = mk(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 16'h000a, 1, 16'h6262, 16'h0000, 1'b0, 1'b0, 11, 16'heb21, 1'b0);
    vecs[1] = mk(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 16'h0008, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 10, 16'h88bb, 1'b0);
    vecs[2] = mk(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 16'h000b, 2, 16'h1234, 16'habcd, 1'b1, 1'b0, 12, 16'h45f6, 1'b0);
    vecs[3] = mk(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 16'h000c, 1, 16'h1111, 16'h0000, 1'b0, 1'b0, 11, 16'h99d4, 1'b1);
    vecs[4] = mk(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 16'h0006, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 10, 16'h88b7, 1'b1);
    vecs[5] = mk(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 16'h000a, 1, 16'h6262, 16'h0000, 1'b1, 1'b0, 11, 16'heabf, 1'b1);
    vecs[6] = mk(32'hc0a80001, 32'hc0a800c7, 16'h1234, 16'h0050, 16'h000c, 2, 16'h4142, 16'h4344, 1'b0, 1'b1, 12, 16'h194d, 1'b0);

    reset_n = 1'b0; start = 1'b0;
    src_ip = '0; dst_ip = '0; src_port = '0; dst_port = '0; udp_length = '0;
    bus.payload_data = '0; bus.payload_valid = 1'b0;
    bus.payload_last = 1'b0; bus.payload_odd = 1'b0;
    csum = 16'h0000;
    clear_counts();
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {11'd0, bus.word_valid, bus.chk_clear, bus.payload_ready, busy, done, bus.word_out},
          32'd0);
    check("reset_len_err", {31'd0, length_error}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vector(vecs[i], i, (i == 0));

    // start arriving in the DONE cycle must be ignored
    @(posedge clk); #1;
    clear_counts();
    load_fields(vecs[1]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!done && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("done_start_timeout", {31'd0, done}, 32'd1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    clr_cnt = 0;
    repeat (4) @(negedge clk);
    check("done_start_busy", {31'd0, busy}, 32'd0);
    check("done_start_clear", clr_cnt, 0);

    // reset asserted while the header is streaming at index 4
    @(posedge clk); #1;
    clear_counts();
    load_fields(vecs[0]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (wv_cnt < 5 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("rst_mid_timeout", wv_cnt, 5);
    #1;
    reset_n = 1'b0;
    bus.payload_valid = 1'b1; bus.payload_data = 16'hffff;
    @(negedge clk);
    check("rst_mid_outputs",
          {11'd0, bus.word_valid, bus.chk_clear, bus.payload_ready, busy, done, bus.word_out},
          32'd0);
    check("rst_mid_len_err", {31'd0, length_error}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.payload_valid = 1'b0; bus.payload_data = 16'h0000;
    done_cnt = 0;
    repeat (20) @(negedge clk);
    check("rst_mid_no_done", done_cnt, 0);
    check("rst_mid_idle", {31'd0, busy}, 32'd0);
    run_vector(vecs[0], 7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
